// File: rtl/core_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : core_reg_bank_if
// Description : Control-unit/datapath bus for the Cortex-M0 register bank.
// Revision    : 1.0
// ============================================================================
interface core_reg_bank_if;
    logic        ld_rd_i;
    logic [3:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        ld_sp_i;
    logic [31:0] sp_data_i;
    logic        ld_lr_i;
    logic [31:0] lr_data_i;
    logic        ld_pc_i;
    logic [31:0] pc_data_i;
    logic        pc_inc_i;
    logic        ld_apsr_i;
    logic [3:0]  apsr_in_i;
    logic        ld_ipsr_i;
    logic [5:0]  ipsr_in_i;
    logic        ld_primask_i;
    logic        primask_in_i;
    logic [3:0]  rn_addr_i;
    logic [3:0]  rm_addr_i;
    logic [31:0] rn_out_o;
    logic [31:0] rm_out_o;
    logic [31:0] sp_out_o;
    logic [31:0] lr_out_o;
    logic [31:0] pc_out_o;
    logic [31:0] xpsr_out_o;
    logic        primask_out_o;

    modport master (
        output ld_rd_i, rd_addr_i, rd_data_i, ld_sp_i, sp_data_i,
               ld_lr_i, lr_data_i, ld_pc_i, pc_data_i, pc_inc_i,
               ld_apsr_i, apsr_in_i, ld_ipsr_i, ipsr_in_i,
               ld_primask_i, primask_in_i, rn_addr_i, rm_addr_i,
        input  rn_out_o, rm_out_o, sp_out_o, lr_out_o, pc_out_o,
               xpsr_out_o, primask_out_o
    );

    modport slave (
        input  ld_rd_i, rd_addr_i, rd_data_i, ld_sp_i, sp_data_i,
               ld_lr_i, lr_data_i, ld_pc_i, pc_data_i, pc_inc_i,
               ld_apsr_i, apsr_in_i, ld_ipsr_i, ipsr_in_i,
               ld_primask_i, primask_in_i, rn_addr_i, rm_addr_i,
        output rn_out_o, rm_out_o, sp_out_o, lr_out_o, pc_out_o,
               xpsr_out_o, primask_out_o
    );
endinterface
`default_nettype wire

// File: rtl/core_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : core_reg_bank
// Description : Cortex-M0 register bank (R0-R12, SP, LR, PC, xPSR, PRIMASK).
// Revision    : 1.0
// ============================================================================
module core_reg_bank #(
    parameter logic [31:0] RESET_SP = 32'h2000_1000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  wire              clk,
    input  wire              rst_n,
    core_reg_bank_if.slave   bus
);
    localparam logic [31:0] C_SP_RST = RESET_SP & ~32'h3;
    localparam logic [31:0] C_PC_RST = RESET_PC & ~32'h1;
    localparam logic [31:0] C_LR_RST = 32'hFFFF_FFFF;

    logic [12:0][31:0] gpr_q, gpr_d;
    logic [31:0]       sp_q, sp_d;
    logic [31:0]       lr_q, lr_d;
    logic [31:0]       pc_q, pc_d;
    logic [3:0]        apsr_q, apsr_d;
    logic [5:0]        ipsr_q, ipsr_d;
    logic              primask_q, primask_d;

    logic w_rd_sp, w_rd_lr, w_rd_pc;
    assign w_rd_sp = bus.ld_rd_i && (bus.rd_addr_i == 4'd13);
    assign w_rd_lr = bus.ld_rd_i && (bus.rd_addr_i == 4'd14);
    assign w_rd_pc = bus.ld_rd_i && (bus.rd_addr_i == 4'd15);

    always_comb begin
        gpr_d = gpr_q;
        for (int i = 0; i < 13; i++) begin
            if (bus.ld_rd_i && (bus.rd_addr_i == 4'(i)))
                gpr_d[i] = bus.rd_data_i;
        end

        sp_d = sp_q;
        if (bus.ld_sp_i)  sp_d = bus.sp_data_i & ~32'h3;
        else if (w_rd_sp) sp_d = bus.rd_data_i & ~32'h3;

        lr_d = lr_q;
        if (bus.ld_lr_i)  lr_d = bus.lr_data_i;
        else if (w_rd_lr) lr_d = bus.rd_data_i;

        // Branch beats register write beats sequential fetch advance
        pc_d = pc_q;
        if (bus.ld_pc_i)       pc_d = bus.pc_data_i & ~32'h1;
        else if (w_rd_pc)      pc_d = bus.rd_data_i & ~32'h1;
        else if (bus.pc_inc_i) pc_d = (pc_q + 32'(PC_STEP)) & ~32'h1;

        apsr_d    = bus.ld_apsr_i    ? bus.apsr_in_i    : apsr_q;
        ipsr_d    = bus.ld_ipsr_i    ? bus.ipsr_in_i    : ipsr_q;
        primask_d = bus.ld_primask_i ? bus.primask_in_i : primask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_q     <= '0;
            sp_q      <= C_SP_RST;
            lr_q      <= C_LR_RST;
            pc_q      <= C_PC_RST;
            apsr_q    <= 4'd0;
            ipsr_q    <= 6'd0;
            primask_q <= 1'b0;
        end else begin
            gpr_q     <= gpr_d;
            sp_q      <= sp_d;
            lr_q      <= lr_d;
            pc_q      <= pc_d;
            apsr_q    <= apsr_d;
            ipsr_q    <= ipsr_d;
            primask_q <= primask_d;
        end
    end

    // Index 15 reads the Thumb pipeline view of PC
    logic [31:0] w_pc_view;
    assign w_pc_view = pc_q + 32'd4;

    always_comb begin
        case (bus.rn_addr_i)
            4'd13:   bus.rn_out_o = sp_q;
            4'd14:   bus.rn_out_o = lr_q;
            4'd15:   bus.rn_out_o = w_pc_view;
            default: bus.rn_out_o = gpr_q[bus.rn_addr_i];
        endcase
    end

    always_comb begin
        case (bus.rm_addr_i)
            4'd13:   bus.rm_out_o = sp_q;
            4'd14:   bus.rm_out_o = lr_q;
            4'd15:   bus.rm_out_o = w_pc_view;
            default: bus.rm_out_o = gpr_q[bus.rm_addr_i];
        endcase
    end

    assign bus.sp_out_o      = sp_q;
    assign bus.lr_out_o      = lr_q;
    assign bus.pc_out_o      = pc_q;
    assign bus.xpsr_out_o    = {apsr_q, 22'd0, ipsr_q};
    assign bus.primask_out_o = primask_q;
endmodule
`default_nettype wire

// File: tb/tb_core_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_reg_bank
// Description : Scoreboard bench for core_reg_bank with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_core_reg_bank;
    localparam int SEL_RN = 0, SEL_RM = 1, SEL_SP = 2, SEL_LR = 3,
                   SEL_PC = 4, SEL_XPSR = 5, SEL_PM = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    event chk_ev;

    core_reg_bank_if bus ();

    core_reg_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Monitor: drains the scoreboard each time the stimulus marks outputs stable
    always begin
        @(chk_ev);
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RN:   act = bus.rn_out_o;
                SEL_RM:   act = bus.rm_out_o;
                SEL_SP:   act = bus.sp_out_o;
                SEL_LR:   act = bus.lr_out_o;
                SEL_PC:   act = bus.pc_out_o;
                SEL_XPSR: act = bus.xpsr_out_o;
                default:  act = {31'd0, bus.primask_out_o};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_rd_i = 0; bus.ld_sp_i = 0; bus.ld_lr_i = 0; bus.ld_pc_i = 0;
        bus.pc_inc_i = 0; bus.ld_apsr_i = 0; bus.ld_ipsr_i = 0; bus.ld_primask_i = 0;
    endtask

    initial begin
        idle();
        bus.rd_addr_i = 0; bus.rd_data_i = 0; bus.sp_data_i = 0; bus.lr_data_i = 0;
        bus.pc_data_i = 0; bus.apsr_in_i = 0; bus.ipsr_in_i = 0; bus.primask_in_i = 0;
        bus.rn_addr_i = 0; bus.rm_addr_i = 0;

        // Asynchronous reset with the clock stopped
        #3 rst_n = 1'b0;
        expect_val("rst_sp", SEL_SP, 32'h2000_1000);
        expect_val("rst_lr", SEL_LR, 32'hFFFF_FFFF);
        expect_val("rst_pc", SEL_PC, 32'h0);
        expect_val("rst_xpsr", SEL_XPSR, 32'h0);
        expect_val("rst_primask", SEL_PM, 32'h0);
        sample();
        for (int r = 0; r < 13; r++) begin
            bus.rn_addr_i = 4'(r);
            expect_val($sformatf("rst_r%0d", r), SEL_RN, 32'h0);
            sample();
        end
        rst_n  = 1'b1;
        clk_en = 1'b1;
        step();

        // GPR write: no bypass, then visible on both ports
        bus.ld_rd_i = 1; bus.rd_addr_i = 5; bus.rd_data_i = 32'hDEAD_BEEF; bus.rn_addr_i = 5;
        expect_val("gpr_no_bypass", SEL_RN, 32'h0);
        sample();
        step();
        idle();
        bus.rm_addr_i = 5;
        expect_val("gpr_rn", SEL_RN, 32'hDEAD_BEEF);
        expect_val("gpr_rm", SEL_RM, 32'hDEAD_BEEF);
        sample();

        // Alignment
        bus.ld_sp_i = 1; bus.sp_data_i = 32'h1234_5677;
        step();
        idle();
        expect_val("sp_align", SEL_SP, 32'h1234_5674);
        sample();
        bus.ld_pc_i = 1; bus.pc_data_i = 32'h0000_0101;
        step();
        idle();
        bus.rn_addr_i = 15;
        expect_val("pc_align", SEL_PC, 32'h100);
        expect_val("pc_view", SEL_RN, 32'h104);
        sample();

        // SP/LR priority with a coincident GPR write
        bus.ld_sp_i = 1; bus.sp_data_i = 32'h0000_4000;
        bus.ld_lr_i = 1; bus.lr_data_i = 32'h0000_AAAA;
        bus.ld_rd_i = 1; bus.rd_addr_i = 13; bus.rd_data_i = 32'h0000_8888;
        step();
        bus.ld_sp_i = 0;
        bus.rd_addr_i = 14; bus.rd_data_i = 32'h0000_BBBB;
        expect_val("sp_prio", SEL_SP, 32'h0000_4000);
        sample();
        step();
        bus.ld_lr_i = 0;
        bus.rd_addr_i = 2; bus.rd_data_i = 32'h0000_0022;
        bus.ld_sp_i = 1; bus.sp_data_i = 32'h0000_5000;
        expect_val("lr_prio", SEL_LR, 32'h0000_AAAA);
        sample();
        step();
        idle();
        bus.rn_addr_i = 2; bus.rm_addr_i = 13;
        expect_val("coincide_r2", SEL_RN, 32'h0000_0022);
        expect_val("coincide_sp", SEL_RM, 32'h0000_5000);
        sample();

        // PC priority
        bus.ld_pc_i = 1; bus.pc_data_i = 32'h200;
        bus.ld_rd_i = 1; bus.rd_addr_i = 15; bus.rd_data_i = 32'h300;
        bus.pc_inc_i = 1;
        step();
        bus.ld_pc_i = 0;
        expect_val("pc_prio_ldpc", SEL_PC, 32'h200);
        sample();
        step();
        bus.ld_rd_i = 0;
        expect_val("pc_prio_rd", SEL_PC, 32'h300);
        sample();
        step(); step(); step();
        idle();
        expect_val("pc_inc3", SEL_PC, 32'h306);
        sample();

        // Status registers
        bus.ld_apsr_i = 1; bus.apsr_in_i = 4'b1010;
        bus.ld_ipsr_i = 1; bus.ipsr_in_i = 6'd11;
        bus.ld_primask_i = 1; bus.primask_in_i = 1'b1;
        step();
        idle();
        expect_val("xpsr", SEL_XPSR, 32'hA000_000B);
        expect_val("primask", SEL_PM, 32'h1);
        sample();

        // Reset asserted before the edge of a pending write
        bus.ld_rd_i = 1; bus.rd_addr_i = 3; bus.rd_data_i = 32'h55; bus.rn_addr_i = 3;
        #2 rst_n = 1'b0;
        step();
        expect_val("rst_mid_r3", SEL_RN, 32'h0);
        expect_val("rst_mid_pc", SEL_PC, 32'h0);
        expect_val("rst_mid_xpsr", SEL_XPSR, 32'h0);
        sample();
        idle();
        rst_n = 1'b1;
        step();
        expect_val("post_rst_r3", SEL_RN, 32'h0);
        sample();

        // PC wrap
        bus.ld_pc_i = 1; bus.pc_data_i = 32'hFFFF_FFFE;
        step();
        bus.ld_pc_i = 0; bus.pc_inc_i = 1; bus.rn_addr_i = 15;
        expect_val("pc_top", SEL_PC, 32'hFFFF_FFFE);
        expect_val("pc_view_wrap", SEL_RN, 32'h2);
        sample();
        step();
        idle();
        expect_val("pc_wrap", SEL_PC, 32'h0);
        sample();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
